// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the push-button debounce array.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input longint unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 64'd1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop synchroniser, debounce FSM, long-press and
// auto-repeat timing with deferral of events that fall due mid-release-check.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_raw,
  output logic o_key_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_repeat
);

  localparam int unsigned DB_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W   = cnt_width(LONG_CYCLES);
  localparam int unsigned REP_W    = cnt_width(REPEAT_CYCLES);
  // Worst-case backlog: everything falling due during one release check.
  localparam int unsigned PEND_MAX = (REPEAT_CYCLES == 0) ? 1
                                   : (DEBOUNCE_CYCLES / REPEAT_CYCLES) + 2;
  localparam int unsigned PEND_W   = cnt_width(PEND_MAX);

  localparam logic [DB_W-1:0]   DB_TARGET   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_TARGET = HOLD_W'(LONG_CYCLES);
  localparam logic [REP_W-1:0]  REP_TARGET  = REP_W'(REPEAT_CYCLES);
  localparam logic [PEND_W-1:0] PEND_TOP    = PEND_W'(PEND_MAX);

  logic [1:0]        r_sync;
  key_state_e        r_state;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic [PEND_W-1:0] r_pend;
  logic              r_long_sent;
  logic              r_level;
  logic              r_press;
  logic              r_release;
  logic              r_long;
  logic              r_repeat;

  logic              w_pressed;
  key_state_e        w_state_nxt;
  logic [DB_W-1:0]   w_db_nxt;
  logic [DB_W-1:0]   w_db_inc;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [HOLD_W-1:0] w_hold_inc;
  logic [REP_W-1:0]  w_rep_nxt;
  logic [REP_W-1:0]  w_rep_inc;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              w_long_sent_nxt;
  logic              w_level_nxt;
  logic              w_press_nxt;
  logic              w_release_nxt;
  logic              w_long_nxt;
  logic              w_repeat_nxt;
  logic              w_timing;
  logic              w_due;
  logic              w_emit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {2{ACTIVE_LOW}};
    end else begin
      r_sync <= {r_sync[0], i_key_raw};
    end
  end

  assign w_pressed  = r_sync[1] ^ ACTIVE_LOW;
  assign w_db_inc   = r_db_cnt + DB_W'(1);
  assign w_hold_inc = r_hold_cnt + HOLD_W'(1);
  assign w_rep_inc  = r_rep_cnt + REP_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_db_nxt        = r_db_cnt;
    w_hold_nxt      = r_hold_cnt;
    w_rep_nxt       = r_rep_cnt;
    w_pend_nxt      = r_pend;
    w_long_sent_nxt = r_long_sent;
    w_level_nxt     = r_level;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_long_nxt      = 1'b0;
    w_repeat_nxt    = 1'b0;
    w_timing        = 1'b0;
    w_due           = 1'b0;
    w_emit          = 1'b0;

    case (r_state)
      ST_RELEASED: begin
        if (w_pressed) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_db_nxt    = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_pressed) begin
          w_state_nxt = ST_RELEASED;
          w_db_nxt    = '0;
        end else if (w_db_inc == DB_TARGET) begin
          w_state_nxt     = ST_HELD;
          w_db_nxt        = '0;
          w_level_nxt     = 1'b1;
          w_press_nxt     = 1'b1;
          w_hold_nxt      = '0;
          w_rep_nxt       = '0;
          w_pend_nxt      = '0;
          w_long_sent_nxt = 1'b0;
        end else begin
          w_db_nxt = w_db_inc;
        end
      end
      ST_HELD: begin
        w_timing = 1'b1;
        if (!w_pressed) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_db_nxt    = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_pressed) begin
          w_state_nxt = ST_HELD;
          w_db_nxt    = '0;
          w_timing    = 1'b1;
        end else if (w_db_inc == DB_TARGET) begin
          w_state_nxt   = ST_RELEASED;
          w_db_nxt      = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
          w_pend_nxt    = '0;
        end else begin
          w_db_nxt = w_db_inc;
          w_timing = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_db_nxt    = '0;
      end
    endcase

    // Hold time keeps running through release checks; due events queue in
    // r_pend and drain one per cycle once the channel is back in HELD.
    if (w_timing) begin
      if (r_hold_cnt != HOLD_TARGET) begin
        w_hold_nxt = w_hold_inc;
        w_due      = (w_hold_inc == HOLD_TARGET);
      end else if (REPEAT_CYCLES != 0) begin
        if (w_rep_inc == REP_TARGET) begin
          w_rep_nxt = '0;
          w_due     = 1'b1;
        end else begin
          w_rep_nxt = w_rep_inc;
        end
      end

      w_emit = (w_state_nxt == ST_HELD) && (w_due || (r_pend != '0));

      if (w_due && !w_emit) begin
        if (r_pend != PEND_TOP) begin
          w_pend_nxt = r_pend + PEND_W'(1);
        end
      end else if (!w_due && w_emit) begin
        w_pend_nxt = r_pend - PEND_W'(1);
      end

      if (w_emit) begin
        if (r_long_sent) begin
          w_repeat_nxt = 1'b1;
        end else begin
          w_long_nxt      = 1'b1;
          w_long_sent_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RELEASED;
      r_db_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_rep_cnt   <= '0;
      r_pend      <= '0;
      r_long_sent <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_db_cnt    <= w_db_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_rep_cnt   <= w_rep_nxt;
      r_pend      <= w_pend_nxt;
      r_long_sent <= w_long_sent_nxt;
      r_level     <= w_level_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
      r_repeat    <= w_repeat_nxt;
    end
  end

  assign o_key_level  = r_level;
  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_long_press = r_long;
  assign o_repeat     = r_repeat;

endmodule

// File: rtl/key_debounce_array.sv
// Array of independent debounced push-button channels sharing one clock.
module key_debounce_array
  import key_debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic                i_CLOCK_50,
  input  logic                i_reset,
  input  logic [NUM_KEYS-1:0] i_key_raw,
  output logic [NUM_KEYS-1:0] o_key_level,
  output logic [NUM_KEYS-1:0] o_press,
  output logic [NUM_KEYS-1:0] o_release,
  output logic [NUM_KEYS-1:0] o_long_press,
  output logic [NUM_KEYS-1:0] o_repeat
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .i_clk        (i_CLOCK_50),
      .i_reset      (i_reset),
      .i_key_raw    (i_key_raw[g]),
      .o_key_level  (o_key_level[g]),
      .o_press      (o_press[g]),
      .o_release    (o_release[g]),
      .o_long_press (o_long_press[g]),
      .o_repeat     (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Scoreboard bench: a time-since-event reference model queues the expected
// output vector each edge; a monitor pops and compares one edge later.
module tb_key_debounce_array;

  localparam int unsigned NK = 4;
  localparam int DB = 4;
  localparam int LG = 20;
  localparam int RP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] raw;
  logic [NK-1:0] lvl, prs, rel, lng, rpt;

  always #5 clk = ~clk;

  key_debounce_array #(
    .NUM_KEYS        (NK),
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LG),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .i_CLOCK_50   (clk),
    .i_reset      (rst),
    .i_key_raw    (raw),
    .o_key_level  (lvl),
    .o_press      (prs),
    .o_release    (rel),
    .o_long_press (lng),
    .o_repeat     (rpt)
  );

  typedef struct packed {
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
    logic [NK-1:0] lng;
    logic [NK-1:0] rpt;
  } outv_t;

  outv_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: a level flips after DB+1 consecutive opposite samples
  // (sample = raw two edges old); events fall due at LG and LG+k*RP edges
  // after the press and are emitted only on edges that sample "pressed".
  bit m_h1[NK], m_h2[NK], m_level[NK], m_long_sent[NK];
  int m_run[NK], m_t[NK], m_pend[NK];

  always @(posedge clk) begin
    outv_t e;
    e = '0;
    cyc++;
    for (int i = 0; i < NK; i++) begin
      bit s;
      bit flip;
      if (rst) begin
        m_h1[i] = 1'b0; m_h2[i] = 1'b0; m_level[i] = 1'b0;
        m_run[i] = 0; m_t[i] = 0; m_pend[i] = 0; m_long_sent[i] = 1'b0;
      end else begin
        s = m_h2[i];
        m_h2[i] = m_h1[i];
        m_h1[i] = ~raw[i];
        flip = 1'b0;
        if (s != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            flip = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        if (flip && s) begin
          m_level[i] = 1'b1; e.prs[i] = 1'b1;
          m_t[i] = 0; m_pend[i] = 0; m_long_sent[i] = 1'b0;
        end else if (flip) begin
          m_level[i] = 1'b0; e.rel[i] = 1'b1; m_pend[i] = 0;
        end else if (m_level[i]) begin
          m_t[i]++;
          if (m_t[i] == LG || (RP > 0 && m_t[i] > LG && (m_t[i] - LG) % RP == 0))
            m_pend[i]++;
          if (s && m_pend[i] > 0) begin
            m_pend[i]--;
            if (!m_long_sent[i]) begin
              e.lng[i] = 1'b1; m_long_sent[i] = 1'b1;
            end else begin
              e.rpt[i] = 1'b1;
            end
          end
        end
      end
      e.lvl[i] = m_level[i];
    end
    exp_q.push_back(e);
  end

  int press_at[NK], rel_at[NK], long_at[NK];
  int press_cnt[NK], rel_cnt[NK], long_cnt[NK];
  int rep0_q[$], rep2_q[$];
  int all_press_at = -1;

  always @(posedge clk) begin
    outv_t e, g;
    #1;
    g.lvl = lvl; g.prs = prs; g.rel = rel; g.lng = lng; g.rpt = rpt;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard @cyc %0d: no expected entry, required one", cyc);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs @cyc %0d: got lvl=%b prs=%b rel=%b lng=%b rpt=%b, required lvl=%b prs=%b rel=%b lng=%b rpt=%b",
                 cyc, g.lvl, g.prs, g.rel, g.lng, g.rpt, e.lvl, e.prs, e.rel, e.lng, e.rpt);
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (prs[i] === 1'b1) begin press_at[i] = cyc; press_cnt[i]++; end
      if (rel[i] === 1'b1) begin rel_at[i] = cyc; rel_cnt[i]++; end
      if (lng[i] === 1'b1) begin long_at[i] = cyc; long_cnt[i]++; end
    end
    if (rpt[0] === 1'b1) rep0_q.push_back(cyc);
    if (rpt[2] === 1'b1) rep2_q.push_back(cyc);
    if (prs === 4'b1111) all_press_at = cyc;
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rep0(output int at);
    int base;
    int w;
    base = rep0_q.size();
    w = 0;
    while (rep0_q.size() == base && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (rep0_q.size() == base) begin
      n_tests++;
      n_fail++;
      $display("FAIL repeat0_timeout: got no repeat[0] in 40 cycles, required one");
      at = cyc;
    end else begin
      at = rep0_q[base];
    end
  endtask

  initial begin
    int e0, s0, r0, rd, c, n, rcnt;
    rst = 1'b1;
    raw = '1;
    tick(3);
    rst = 1'b0;
    tick(5);

    // Clean press on key 0 (held from here on).
    raw[0] = 1'b0; e0 = cyc + 1;
    tick(10);
    check("press0_latency", press_at[0] - e0, 6);
    check("press0_count", press_cnt[0], 1);
    check("level0_high", int'(lvl[0]), 1);
    check("others_no_press", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // Bounce on key 1: 10 half-periods of 2 cycles, then settle pressed.
    for (int k = 0; k < 10; k++) begin
      raw[1] = k[0];
      tick(2);
    end
    raw[1] = 1'b0; s0 = cyc + 1;
    check("bounce1_no_press", press_cnt[1], 0);
    tick(10);
    check("press1_after_settle", press_at[1] - s0, 6);
    check("press1_count", press_cnt[1], 1);

    // Long press and repeat on key 2.
    raw[2] = 1'b0; e0 = cyc + 1;
    tick(60);
    raw[2] = 1'b1; r0 = cyc + 1;
    tick(10);
    check("press2_latency", press_at[2] - e0, 6);
    check("long2_offset", long_at[2] - press_at[2], 20);
    check("long2_count", long_cnt[2], 1);
    check("repeat2_count", rep2_q.size(), 4);
    for (int k = 0; k < 4 && k < rep2_q.size(); k++)
      check("repeat2_offset", rep2_q[k] - press_at[2], 28 + 8 * k);
    check("release2_latency", rel_at[2] - r0, 6);
    check("release2_count", rel_cnt[2], 1);

    // Release glitch on key 0 away from a due repeat, then one straddling it.
    wait_rep0(c);
    raw[0] = 1'b1; tick(2); raw[0] = 1'b0;
    wait_rep0(n);
    check("glitch_repeat_spacing", n - c, 8);
    c = n;
    tick(5);
    raw[0] = 1'b1; tick(2); raw[0] = 1'b0;
    wait_rep0(n);
    check("deferred_repeat", n - c, 10);
    wait_rep0(n);
    check("repeat_phase_kept", n - c, 16);
    check("glitch_no_release0", rel_cnt[0], 0);
    check("glitch_level0", int'(lvl[0]), 1);

    // Reset while key 3 is held.
    raw[3] = 1'b0;
    tick(30);
    rcnt = rel_cnt[3];
    rst = 1'b1;
    tick(1);
    check("reset_outputs_zero", int'({lvl, prs, rel, lng, rpt}), 0);
    rst = 1'b0; rd = cyc + 1;
    tick(12);
    check("press3_after_reset", press_at[3] - rd, 6);
    check("reset_no_release3", rel_cnt[3], rcnt);

    // Simultaneous press on all channels.
    raw = '1;
    tick(20);
    raw = '0; s0 = cyc + 1;
    tick(10);
    check("all_press_same_cycle", all_press_at - s0, 6);
    for (int i = 0; i < NK; i++)
      check("all_press_each", press_at[i] - s0, 6);

    // Randomized traffic with bounces, long holds and occasional reset.
    begin
      int hold_left[NK];
      for (int i = 0; i < NK; i++) hold_left[i] = 0;
      for (int t = 0; t < 2500; t++) begin
        rst = ($urandom_range(0, 399) == 0);
        for (int i = 0; i < NK; i++) begin
          if (hold_left[i] == 0) begin
            raw[i] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
              0: hold_left[i] = $urandom_range(1, 3);
              1: hold_left[i] = $urandom_range(4, 12);
              default: hold_left[i] = $urandom_range(15, 60);
            endcase
          end else begin
            hold_left[i]--;
          end
        end
        tick(1);
      end
      rst = 1'b0;
    end
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of independent push-button channels, range 1..16.
REQ-002 Parameter ACTIVE_LOW, default 1: 1 = raw key reads 0 when pressed (DE1-SoC KEY convention); 0 = reads 1 when pressed.
REQ-003 Parameter DEBOUNCE_CYCLES, default 250000: stable-sample count required to accept a level change (5 ms at 50 MHz), minimum 1.
REQ-004 Parameter LONG_CYCLES, default 50000000: held duration after the accepted press that raises long_press (1 s), minimum 1.
REQ-005 Parameter REPEAT_CYCLES, default 10000000: auto-repeat period after long_press; 0 disables repeat.
REQ-006 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 key_raw  in  NUM_KEYS  asynchronous button inputs, polarity per ACTIVE_LOW.
REQ-009 key_level  out  NUM_KEYS  debounced state, 1 = pressed, always active-high.
REQ-010 press  out  NUM_KEYS  one-cycle pulse on accepted press.
REQ-011 release  out  NUM_KEYS  one-cycle pulse on accepted release.
REQ-012 long_press  out  NUM_KEYS  one-cycle pulse when held LONG_CYCLES after press.
REQ-013 repeat  out  NUM_KEYS  one-cycle pulse every REPEAT_CYCLES after long_press while held.

Function
REQ-014 Each channel shall pass key_raw through a 2-flop synchroniser, then normalise to active-high before any other logic.
REQ-015 Each channel shall run an FSM: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-016 RELEASED -> PRESS_WAIT when the synchronised value reads pressed; counter cleared.
REQ-017 PRESS_WAIT: counter increments each cycle the value reads pressed; any released sample returns to RELEASED with counter cleared (bounce rejection).
REQ-018 PRESS_WAIT -> HELD when the counter reaches DEBOUNCE_CYCLES; press and key_level asserted on that same registered cycle.
REQ-019 Clean press latency: press high exactly 2 + DEBOUNCE_CYCLES cycles after the first edge sampling a pressed key_raw.
REQ-020 HELD: hold counter shall count from press; long_press pulses once when it reaches LONG_CYCLES; thereafter, if REPEAT_CYCLES > 0, repeat pulses every REPEAT_CYCLES cycles; hold counter saturates, never wraps.
REQ-021 HELD -> RELEASE_WAIT on a released sample; key_level stays 1; debounce counter cleared.
REQ-022 RELEASE_WAIT: a pressed sample returns to HELD with hold/repeat timing continuing uninterrupted; DEBOUNCE_CYCLES consecutive released samples -> RELEASED, release pulses and key_level drops on that cycle.
REQ-023 long_press/repeat shall not fire in RELEASE_WAIT; a due event is deferred to the next HELD cycle, never dropped or duplicated.
REQ-024 press, release, long_press, repeat shall be mutually exclusive per channel per cycle; channels fully independent, simultaneous events on different channels allowed.
REQ-025 Counter widths shall be $clog2(max value + 1); no truncation for any legal parameter.
REQ-026 All outputs registered; no combinational path from key_raw to any output.

Reset
REQ-027 reset high at a clock edge: all FSMs to RELEASED, all counters 0, synchroniser flops to the released level, all outputs 0 on the following cycle.
REQ-028 Reset mid-press shall emit no release pulse; a key held through reset deassertion shall be re-debounced and produce a fresh press per REQ-019.

Structure
REQ-029 Shared package key_debounce_pkg shall hold the FSM state enum and a counter-width helper function.
REQ-030 One sub-module key_debounce_ch (single channel: synchroniser, FSM, counters) shall be instantiated NUM_KEYS times by a generate loop; top holds no other logic.

Verification (bench parameters: NUM_KEYS=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8)
REQ-031 Clean press: key_raw[0] 1->0 held -> press[0] single pulse exactly 6 cycles later, key_level[0]=1; other channels stay 0.
REQ-032 Bounce: key_raw[1] toggles 0/1 every 2 cycles for 20 cycles then holds 0 -> no pulse during bounce; exactly one press[1] 6 cycles after final settle.
REQ-033 Long/repeat: key_raw[2] held 0 for 60 cycles -> long_press[2] 20 cycles after press[2], repeat[2] at +28, +36, +44 ...; release then one release[2] 6 cycles after key_raw returns to 1.
REQ-034 Release glitch: while key_level[0]=1 a 2-cycle high glitch -> no release, key_level stays 1, repeat timing unchanged.
REQ-035 Reset mid-hold: assert reset 1 cycle while key_raw[3] held 0 -> all outputs 0 next cycle, no release; fresh press[3] 6 cycles after reset drops.
REQ-036 Simultaneous: all four keys pressed on the same edge -> press[3:0]=4'b1111 on one cycle.
